// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NUM_RD = 2;
  localparam int unsigned ZERO_ADDR  = 0;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One architectural register plus its pending (scoreboard) bit.
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic              flush,
  output logic [DATA_W-1:0] data,
  output logic              pend,
  output logic              pend_nxt_c
);

  // Issue beats flush beats writeback clear: a new producer supersedes the old one.
  assign pend_nxt_c = iss_en | (pend & ~flush & ~wr_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      pend <= 1'b0;
    end else begin
      if (wr_en) data <= wr_data;
      pend <= pend_nxt_c;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register pending bits for decode-stage stalls.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW = clog2(DEPTH),
  localparam int unsigned CW = clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     flush,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  output logic                     stall,
  output logic [CW-1:0]            pend_cnt
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  iss_sel;
  logic              wr_hit;
  logic [CW-1:0]     cnt_nxt;

  // Address decode; out-of-range addresses match no cell and are dropped.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_reg
    if (ZERO_REG && i == int'(ZERO_ADDR)) begin : g_zero
      assign wr_sel[i]   = 1'b0;
      assign iss_sel[i]  = 1'b0;
      assign regs[i]     = '0;
      assign pend[i]     = 1'b0;
      assign pend_nxt[i] = 1'b0;
    end else begin : g_cell
      assign wr_sel[i]  = wr_en  && (wr_addr  == AW'(i));
      assign iss_sel[i] = iss_en && (iss_addr == AW'(i));

      regfile_cell #(.DATA_W(DATA_W)) u_cell (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_sel[i]),
        .wr_data    (wr_data),
        .iss_en     (iss_sel[i]),
        .flush      (flush),
        .data       (regs[i]),
        .pend       (pend[i]),
        .pend_nxt_c (pend_nxt[i])
      );
    end
  end

  // A write that actually lands in a real register; only those may be forwarded.
  assign wr_hit = |wr_sel;

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] d;
    logic              p;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      d = '0;
      p = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (addr == AW'(j)) begin
          d = regs[j];
          p = pend[j];
        end
      end
      if (BYPASS && wr_hit && (addr == wr_addr)) begin
        d = wr_data;
        p = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_pend[k]                  = p;
  end

  assign stall = |(rd_use & rd_pend);

  // Count tracks the pending vector it will sit beside after the edge.
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      cnt_nxt = cnt_nxt + CW'(pend_nxt[j]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_cnt <= '0;
    else        pend_cnt <= cnt_nxt;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: table of single-cycle vectors on the default build, plus hand
// sequences on a BYPASS=0, non-power-of-2 build and a mid-cycle reset.
module tb_regfile_scoreboard;

  logic clk;
  logic reset;

  // Default build: DEPTH=32, NUM_RD=2, ZERO_REG=1, BYPASS=1
  logic        wr_en, iss_en, flush;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        stall;
  logic [5:0]  pend_cnt;

  // Second build: DEPTH=12, NUM_RD=1, BYPASS=0
  logic        wr_en2, iss_en2, flush2;
  logic [3:0]  wr_addr2, iss_addr2, rd_addr2;
  logic [31:0] wr_data2;
  logic        rd_use2;
  logic [31:0] rd_data2;
  logic        rd_pend2;
  logic        stall2;
  logic [3:0]  pend_cnt2;

  int total;
  int bad;

  regfile_scoreboard u_dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data), .rd_pend(rd_pend), .stall(stall), .pend_cnt(pend_cnt)
  );

  regfile_scoreboard #(.DATA_W(32), .DEPTH(12), .NUM_RD(1), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut2 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .iss_en(iss_en2), .iss_addr(iss_addr2), .flush(flush2),
    .rd_addr(rd_addr2), .rd_use(rd_use2),
    .rd_data(rd_data2), .rd_pend(rd_pend2), .stall(stall2), .pend_cnt(pend_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  ruse;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  pend;
    logic        stall;
    logic [5:0]  cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] u,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] ep, input logic es, input logic [5:0] ec);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.iss_en = ie; v.iss_addr = ia; v.flush = fl;
    v.ra0 = a0; v.ra1 = a1; v.ruse = u;
    v.d0 = e0; v.d1 = e1; v.pend = ep; v.stall = es; v.cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    rd_addr = '0; rd_use = '0;
    wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    iss_en2 = 1'b0; iss_addr2 = '0; flush2 = 1'b0;
    rd_addr2 = '0; rd_use2 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //           we  wa     wd            ie  ia     fl  a0     a1     use    d0            d1            pend   st    cnt
    vecs[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd31, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
    vecs[1]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  0, 5'd7,  5'd0,  2'b01, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0);
    vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd7,  5'd0,  2'b01, 32'h0,        32'h0,        2'b01, 1'b1, 6'd1);
    vecs[3]  = mk(1, 5'd7,  32'hDEADBEEF, 0, 5'd0,  0, 5'd7,  5'd7,  2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 6'd1);
    vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd7,  5'd5,  2'b11, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0, 6'd0);
    vecs[5]  = mk(1, 5'd3,  32'h33,       1, 5'd3,  0, 5'd3,  5'd3,  2'b11, 32'h33,       32'h33,       2'b00, 1'b0, 6'd0);
    vecs[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd3,  5'd7,  2'b01, 32'h33,       32'hDEADBEEF, 2'b01, 1'b1, 6'd1);
    vecs[7]  = mk(0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd3,  5'd4,  2'b10, 32'h33,       32'h0,        2'b01, 1'b0, 6'd1);
    vecs[8]  = mk(0, 5'd0,  32'h0,        1, 5'd5,  0, 5'd4,  5'd5,  2'b11, 32'h0,        32'h0,        2'b01, 1'b1, 6'd2);
    vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd5,  5'd9,  2'b00, 32'h0,        32'h0,        2'b01, 1'b0, 6'd3);
    vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd9,  5'd3,  2'b11, 32'h0,        32'h33,       2'b01, 1'b1, 6'd1);
    vecs[11] = mk(1, 5'd0,  32'h1234,     1, 5'd0,  0, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0,        2'b00, 1'b0, 6'd1);
    vecs[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd9,  2'b11, 32'h0,        32'h0,        2'b10, 1'b1, 6'd1);
    vecs[13] = mk(1, 5'd9,  32'h99,       0, 5'd0,  1, 5'd9,  5'd0,  2'b11, 32'h99,       32'h0,        2'b00, 1'b0, 6'd1);
    vecs[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd9,  5'd3,  2'b11, 32'h99,       32'h33,       2'b00, 1'b0, 6'd0);

    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #10 reset = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr; flush = vecs[i].flush;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      rd_use = vecs[i].ruse;
      #1;
      check($sformatf("v%0d rd_data0", i), 64'(rd_data[31:0]), 64'(vecs[i].d0));
      check($sformatf("v%0d rd_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].d1));
      check($sformatf("v%0d rd_pend", i), 64'(rd_pend), 64'(vecs[i].pend));
      check($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].stall));
      check($sformatf("v%0d pend_cnt", i), 64'(pend_cnt), 64'(vecs[i].cnt));
      step();
    end
    idle_inputs();

    // No-bypass build: pending survives the writeback cycle, data appears next cycle.
    iss_en2 = 1'b1; iss_addr2 = 4'd2; rd_addr2 = 4'd2; rd_use2 = 1'b1;
    #1;
    check("nb issue same-cycle pend", 64'(rd_pend2), 64'd0);
    step();
    iss_en2 = 1'b0;
    #1;
    check("nb pend after issue", 64'(rd_pend2), 64'd1);
    check("nb stall after issue", 64'(stall2), 64'd1);
    check("nb pend_cnt after issue", 64'(pend_cnt2), 64'd1);
    wr_en2 = 1'b1; wr_addr2 = 4'd2; wr_data2 = 32'hA5A5A5A5;
    #1;
    check("nb old data during write", 64'(rd_data2), 64'd0);
    check("nb old pend during write", 64'(rd_pend2), 64'd1);
    step();
    wr_en2 = 1'b0;
    #1;
    check("nb new data after write", 64'(rd_data2), 64'hA5A5A5A5);
    check("nb pend cleared", 64'(rd_pend2), 64'd0);
    check("nb pend_cnt cleared", 64'(pend_cnt2), 64'd0);

    // Out-of-range addresses on the 12-entry build.
    wr_en2 = 1'b1; wr_addr2 = 4'd13; wr_data2 = 32'hFFFFFFFF;
    iss_en2 = 1'b1; iss_addr2 = 4'd14; rd_addr2 = 4'd13;
    #1;
    check("oor read during write", 64'(rd_data2), 64'd0);
    step();
    wr_en2 = 1'b0; iss_en2 = 1'b0;
    #1;
    check("oor read data", 64'(rd_data2), 64'd0);
    check("oor read pend", 64'(rd_pend2), 64'd0);
    check("oor pend_cnt", 64'(pend_cnt2), 64'd0);
    rd_addr2 = 4'd14;
    #1;
    check("oor issued addr pend", 64'(rd_pend2), 64'd0);
    idle_inputs();

    // Fill registers 1..10 and mark 21..24 pending, then reset between edges.
    for (int i = 1; i <= 10; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
      iss_en = (i <= 4); iss_addr = 5'(20 + i);
      step();
    end
    idle_inputs();
    rd_addr = {5'd21, 5'd10}; rd_use = 2'b11;
    #1;
    check("pre-reset data10", 64'(rd_data[31:0]), 64'h10A);
    check("pre-reset pend21", 64'(rd_pend), 64'b10);
    check("pre-reset pend_cnt", 64'(pend_cnt), 64'd4);
    #1 reset = 1'b0;
    #1;
    check("async reset data10", 64'(rd_data[31:0]), 64'd0);
    check("async reset pend", 64'(rd_pend), 64'd0);
    check("async reset stall", 64'(stall), 64'd0);
    check("async reset pend_cnt", 64'(pend_cnt), 64'd0);
    rd_addr = {5'd1, 5'd5};
    #1;
    check("async reset data5", 64'(rd_data[31:0]), 64'd0);
    check("async reset data1", 64'(rd_data[63:32]), 64'd0);
    #1 reset = 1'b1;
    step();
    check("post-reset pend_cnt", 64'(pend_cnt), 64'd0);
    check("post-reset data1", 64'(rd_data[63:32]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
